fetch_unit: RTL and testbench

Instruction-fetch stage of `PipelinedCPU`. Owns the program counter, drives the synchronous-read instruction memory, and buffers returned words in a 2-entry FIFO so decode back-pressure never drops a fetched instruction. Decode consumes its output through a valid/ready handshake. Branch/jump resolution redirects it, discarding everything in flight.

---
 rtl/fetch_unit.sv | 119 +++++++++++
 tb/tb_fetch_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC generation, synchronous imem requests, 2-entry decode FIFO.
// Optional FETCH_MISALIGN_CHECK_EN: misaligned redirects raise a sticky fetch_fault and halt fetch.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    input  logic        id_ready,
    output logic        fetch_fault
);

    logic [31:0] pc_q;
    logic        run_q;
    logic        inflight_q;
    logic        inflight_epoch_q;
    logic        epoch_q;
    logic [1:0]  count_q;
    logic [31:0] fifo_pc    [2];
    logic [31:0] fifo_instr [2];

    logic        pop;
    logic        push;
    logic        issue;
    logic        halted;
    logic        misaligned;
    logic [31:0] target_pc;
    logic [1:0]  fill;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic fault_q;
    assign target_pc   = redirect_pc;
    assign misaligned  = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign halted      = fault_q;
    assign fetch_fault = fault_q;
`else
    assign target_pc   = redirect_pc & 32'hFFFF_FFFC;
    assign misaligned  = 1'b0;
    assign halted      = 1'b0;
    assign fetch_fault = 1'b0;
`endif

    assign if_valid = (count_q != 2'd0);
    assign if_pc    = if_valid ? fifo_pc[0]    : 32'h0000_0000;
    assign if_instr = if_valid ? fifo_instr[0] : NOP_INSTR;

    assign pop  = if_valid && id_ready;
    // A response whose epoch tag is stale belongs to a squashed stream.
    assign push = inflight_q && (inflight_epoch_q == epoch_q);
    assign fill = count_q - {1'b0, pop};

    // Only issue when the word can land without overflowing the FIFO.
    assign issue = run_q && !redirect_valid && !halted &&
                   (({1'b0, count_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));

    assign imem_req  = issue;
    assign imem_addr = pc_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q             <= RESET_PC;
            run_q            <= 1'b0;
            inflight_q       <= 1'b0;
            inflight_epoch_q <= 1'b0;
            epoch_q          <= 1'b0;
            count_q          <= 2'd0;
            fifo_pc[0]       <= 32'h0000_0000;
            fifo_pc[1]       <= 32'h0000_0000;
            fifo_instr[0]    <= NOP_INSTR;
            fifo_instr[1]    <= NOP_INSTR;
`ifdef FETCH_MISALIGN_CHECK_EN
            fault_q          <= 1'b0;
`endif
        end else begin
            run_q <= 1'b1;
            if (redirect_valid) begin
                count_q    <= 2'd0;
                epoch_q    <= ~epoch_q;
                pc_q       <= target_pc;
                inflight_q <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
                if (misaligned) begin
                    fault_q <= 1'b1;
                end
`endif
            end else begin
                if (pop) begin
                    fifo_pc[0]    <= fifo_pc[1];
                    fifo_instr[0] <= fifo_instr[1];
                end
                // The push slot is the first free entry after any same-cycle pop.
                if (push) begin
                    fifo_pc[fill[0]]    <= pc_q - 32'd4;
                    fifo_instr[fill[0]] <= imem_rdata;
                end
                count_q <= count_q + {1'b0, push} - {1'b0, pop};
                if (issue) begin
                    pc_q             <= pc_q + 32'd4;
                    inflight_q       <= 1'b1;
                    inflight_epoch_q <= epoch_q;
                end else begin
                    inflight_q <= 1'b0;
                end
            end
        end
    end

    logic unused_misaligned;
    assign unused_misaligned = misaligned;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: synchronous imem model, delivered-stream scoreboard and directed timing checks.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        id_ready;
    logic        fetch_fault;

    int passCount;
    int checkCount;

    logic [31:0] expPc;
    logic        expFault;
    logic        expEpoch;

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_req       (imem_req),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .id_ready       (id_ready),
        .fetch_fault    (fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h1234_5037;
            32'h0000_0004: return 32'h0010_8113;
            32'h0000_0008: return 32'h0020_2023;
            default:       return a ^ 32'h5A5A_1234;
        endcase
    endfunction

    // Synchronous-read instruction memory: data appears the cycle after the request.
    initial imem_rdata = 32'h0;
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= memWord(imem_addr);
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    endtask

    task automatic applyStimulus(input logic rstV, input logic redirV, input logic [31:0] redirPcV, input logic readyV);
        @(posedge clk);
        #1;
        rst            = rstV;
        redirect_valid = redirV;
        redirect_pc    = redirPcV;
        id_ready       = readyV;
    endtask

    task automatic resetDut(input logic readyV);
        applyStimulus(1'b0, 1'b0, 32'h0, readyV);
        applyStimulus(1'b1, 1'b0, 32'h0, readyV);
    endtask

    // Scoreboard: the head must always be the next PC of the architectural stream.
    always @(negedge clk) begin
        if (!rst) begin
            checkOutput("rstValid", {31'h0, if_valid}, 32'h0);
            checkOutput("rstReq", {31'h0, imem_req}, 32'h0);
            checkOutput("rstAddr", imem_addr, 32'h0);
            checkOutput("rstInstr", if_instr, NOP);
            expPc    = 32'h0;
            expFault = 1'b0;
            expEpoch = 1'b0;
        end else begin
            checkOutput("fault", {31'h0, fetch_fault}, {31'h0, expFault});
            checkOutput("epoch", {31'h0, dut.epoch_q}, {31'h0, expEpoch});
            if (if_valid) begin
                checkOutput("headPc", if_pc, expPc);
                checkOutput("headInstr", if_instr, memWord(expPc));
            end else begin
                checkOutput("idlePc", if_pc, 32'h0);
                checkOutput("idleInstr", if_instr, NOP);
            end
            if (expFault) checkOutput("validWhileFault", {31'h0, if_valid}, 32'h0);
            if (imem_req) checkOutput("addrAlign", {30'h0, imem_addr[1:0]}, 32'h0);
            if (if_valid && id_ready) expPc = expPc + 32'd4;
            if (redirect_valid) begin
                expEpoch = ~expEpoch;
`ifdef FETCH_MISALIGN_CHECK_EN
                if (redirect_pc[1:0] != 2'b00) expFault = 1'b1;
                expPc = redirect_pc;
`else
                expPc = {redirect_pc[31:2], 2'b00};
`endif
            end
        end
    end

    initial begin
        rst            = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        id_ready       = 1'b1;
        passCount      = 0;
        checkCount     = 0;
        expPc          = 32'h0;
        expFault       = 1'b0;
        expEpoch       = 1'b0;

        // Reset release and first three instructions back to back.
        resetDut(1'b1);
        @(negedge clk); checkOutput("preE0Req", {31'h0, imem_req}, 32'h0);
        @(negedge clk); checkOutput("e0Req", {31'h0, imem_req}, 32'h1);
                        checkOutput("e0Addr", imem_addr, 32'h0);
                        checkOutput("e0Valid", {31'h0, if_valid}, 32'h0);
        @(negedge clk); checkOutput("e1Addr", imem_addr, 32'h4);
                        checkOutput("e1Valid", {31'h0, if_valid}, 32'h0);
        @(negedge clk); checkOutput("e2Valid", {31'h0, if_valid}, 32'h1);
                        checkOutput("e2Pc", if_pc, 32'h0);
                        checkOutput("e2Instr", if_instr, 32'h1234_5037);
        @(negedge clk); checkOutput("e3Pc", if_pc, 32'h4);
                        checkOutput("e3Instr", if_instr, 32'h0010_8113);
        @(negedge clk); checkOutput("e4Pc", if_pc, 32'h8);
                        checkOutput("e4Instr", if_instr, 32'h0020_2023);

        // Decode stall right from the first valid word.
        resetDut(1'b0);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("stallPc", if_pc, 32'h0);
            checkOutput("stallInstr", if_instr, 32'h1234_5037);
            if (i >= 1) begin
                checkOutput("stallReq", {31'h0, imem_req}, 32'h0);
                checkOutput("stallCount", {30'h0, dut.count_q}, 32'h2);
            end
        end
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        @(negedge clk); checkOutput("drain0", if_pc, 32'h0);
        @(negedge clk); checkOutput("drain1", if_pc, 32'h4);
        @(negedge clk); checkOutput("drain2", if_pc, 32'h8);

        // Redirect while the FIFO is full.
        repeat (3) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'h100, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        @(negedge clk); checkOutput("rdFullV1", {31'h0, if_valid}, 32'h0);
                        checkOutput("rdFullAddr", imem_addr, 32'h100);
        @(negedge clk); checkOutput("rdFullV2", {31'h0, if_valid}, 32'h0);
        @(negedge clk); checkOutput("rdFullPc", if_pc, 32'h100);
                        checkOutput("rdFullInstr", if_instr, 32'h5A5A_1334);

        // Redirect while streaming with a read in flight.
        repeat (2) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b1, 1'b1, 32'h200, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        @(negedge clk); checkOutput("rdFlyV1", {31'h0, if_valid}, 32'h0);
        @(negedge clk); checkOutput("rdFlyV2", {31'h0, if_valid}, 32'h0);
        @(negedge clk); checkOutput("rdFlyPc", if_pc, 32'h200);

        // Stall, then redirect in the same cycle decode accepts the head.
        repeat (3) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'h100, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        @(negedge clk); checkOutput("rdPopV1", {31'h0, if_valid}, 32'h0);
                        checkOutput("epochAfter3", {31'h0, dut.epoch_q}, 32'h1);
        @(negedge clk); checkOutput("rdPopV2", {31'h0, if_valid}, 32'h0);
        @(negedge clk); checkOutput("rdPopPc0", if_pc, 32'h100);
        @(negedge clk); checkOutput("rdPopPc1", if_pc, 32'h104);

        // PC wrap-around.
        applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        repeat (2) @(negedge clk);
        @(negedge clk); checkOutput("wrapPc0", if_pc, 32'hFFFF_FFFC);
        @(negedge clk); checkOutput("wrapPc1", if_pc, 32'h0);

        // Asynchronous reset pulse mid-stream.
        repeat (2) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        checkOutput("asyncValid", {31'h0, if_valid}, 32'h0);
        checkOutput("asyncPc", if_pc, 32'h0);
        checkOutput("asyncInstr", if_instr, NOP);
        checkOutput("asyncReq", {31'h0, imem_req}, 32'h0);
        checkOutput("asyncAddr", imem_addr, 32'h0);
        checkOutput("asyncFault", {31'h0, fetch_fault}, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        repeat (3) @(negedge clk);
        @(negedge clk); checkOutput("restartValid", {31'h0, if_valid}, 32'h1);
                        checkOutput("restartPc", if_pc, 32'h0);

        // Misaligned redirect.
        repeat (3) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b1, 1'b1, 32'h102, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
`ifdef FETCH_MISALIGN_CHECK_EN
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("misFault", {31'h0, fetch_fault}, 32'h1);
            checkOutput("misValid", {31'h0, if_valid}, 32'h0);
        end
`else
        repeat (2) @(negedge clk);
        @(negedge clk); checkOutput("misPc", if_pc, 32'h100);
                        checkOutput("misFault", {31'h0, fetch_fault}, 32'h0);
`endif

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
